decode_queue: RTL



---
 rtl/decode_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// decode_queue: decode stage for the 16-bit ISA with a DEPTH-entry FIFO
// between fetch and register read. Instructions are decoded when they are
// pushed, and the decoded fields are stored next to the raw word and its PC.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   fetch-side handshake; in_inst/in_pc carry the instruction
//   flush            synchronous discard of buffered and incoming entries
//   out_valid/ready  consumer-side handshake on the head entry
//   out_rs/rt/rd     register specifiers of the head entry
//   out_imm/disp     immediate / jump displacement, extended to DATA_W
//   out_pc/inst      PC and raw word of the head entry
//   perf_decoded     (DECODE_QUEUE_PERF_EN only) count of pushes
//   perf_stall       (DECODE_QUEUE_PERF_EN only) cycles with in_valid && !in_ready
//
// Optional feature macro: DECODE_QUEUE_PERF_EN.
module decode_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_rs,
  output logic [2:0]        out_rt,
  output logic [2:0]        out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_disp,
  output logic [PC_W-1:0]   out_pc,
  output logic [15:0]       out_inst
`ifdef DECODE_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_decoded,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 16 + PC_W + 9 + 2 * DATA_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // Decoder
  logic [2:0]        dec_rs, dec_rt, dec_rd;
  logic [DATA_W-1:0] dec_imm, dec_disp;
  logic [DATA_W-1:0] sext5, zext5, sext8, zext8, sext11;

  assign sext5  = {{(DATA_W - 5){in_inst[4]}}, in_inst[4:0]};
  assign zext5  = {{(DATA_W - 5){1'b0}}, in_inst[4:0]};
  assign sext8  = {{(DATA_W - 8){in_inst[7]}}, in_inst[7:0]};
  assign zext8  = {{(DATA_W - 8){1'b0}}, in_inst[7:0]};
  assign sext11 = {{(DATA_W - 11){in_inst[10]}}, in_inst[10:0]};

  always_comb begin
    dec_rs   = '0;
    dec_rt   = '0;
    dec_rd   = '0;
    dec_imm  = '0;
    dec_disp = '0;
    case (in_inst[15:13])
      3'b010: begin
        dec_rs  = in_inst[10:8];
        dec_rd  = in_inst[7:5];
        dec_imm = in_inst[12] ? zext5 : sext5;
      end
      3'b101: begin
        dec_rs  = in_inst[10:8];
        dec_rd  = in_inst[7:5];
        dec_imm = sext5;
      end
      3'b100: begin
        dec_rs = in_inst[10:8];
        if (in_inst[12:11] == 2'b10) begin
          dec_imm = zext8;
        end else begin
          dec_rd  = in_inst[7:5];
          dec_imm = sext5;
        end
      end
      3'b110, 3'b111: begin
        dec_rs = in_inst[10:8];
        dec_rt = in_inst[7:5];
        dec_rd = in_inst[4:2];
      end
      3'b011: begin
        dec_rs  = in_inst[10:8];
        dec_imm = sext8;
      end
      3'b001: begin
        if (in_inst[11]) dec_imm = sext8;
        else             dec_disp = sext11;
      end
      default: ;
    endcase
  end

  // Buffer
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] entry, head;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign entry     = {in_inst, in_pc, dec_rs, dec_rt, dec_rd, dec_imm, dec_disp};
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_inst, out_pc, out_rs, out_rt, out_rd, out_imm, out_disp} = head;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A push coinciding with flush is dropped along with the contents.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef DECODE_QUEUE_PERF_EN
  logic [31:0] perf_decoded_q, perf_decoded_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_decoded_d = perf_decoded_q;
    perf_stall_d   = perf_stall_q;
    if (push)                   perf_decoded_d = perf_decoded_q + 32'd1;
    if (in_valid && !in_ready)  perf_stall_d   = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
